serial_pattern_gen: RTL

//  Parallel-to-serial bit-stream transmitter. Accepts a WIDTH-bit word on a load strobe and

---
 rtl/serial_pattern_gen.sv | 76 +++++++
 1 files changed

// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial frame transmitter: one WIDTH-bit word per load, one bit per clock.
// Define MSB_FIRST_EN to transmit the most significant bit first (default is LSB first).
module serial_pattern_gen #(
    parameter int   WIDTH    = 32,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        // First bit goes straight to dout; the rest wait in shreg.
`ifdef MSB_FIRST_EN
                        shreg <= data_in << 1;
                        dout  <= data_in[WIDTH-1];
`else
                        shreg <= data_in >> 1;
                        dout  <= data_in[0];
`endif
                        dout_valid <= 1'b1;
                        cnt        <= CW'(1);
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST_CNT) begin
                        dout       <= IDLE_BIT;
                        dout_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
`ifdef MSB_FIRST_EN
                        dout  <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
`else
                        dout  <= shreg[0];
                        shreg <= shreg >> 1;
`endif
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
